// File: rtl/life_sequencer.sv
// Generation sequencer for a cellular-automaton grid.
// Drives LFSR/grid control and counts generations.
module life_sequencer #(
  parameter int CNT_W    = 24,
  parameter int GEN_W    = 16,
  parameter int SEED_CYC = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             step,
  input  logic             seed_req,
  input  logic [CNT_W-1:0] rate,
  output logic             lfsr_rst,
  output logic             lfsr_load,
  output logic             grid_rst,
  output logic             grid_en,
  output logic [GEN_W-1:0] gen_count,
  output logic             gen_wrap,
  output logic             busy,
  output logic [2:0]       state_o
);

  localparam int SW = (SEED_CYC > 1) ? $clog2(SEED_CYC) : 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    RUN   = 3'd2,
    PAUSE = 3'd3,
    STEP  = 3'd4
  } state_t;

  state_t           state;
  state_t           nxt;
  logic [CNT_W-1:0] div;
  logic [CNT_W-1:0] rate_q;
  logic [SW-1:0]    seed_cnt;
  logic             seed_last;
  logic             hit;
  logic             tick;
  logic [GEN_W-1:0] gen_inc;

  // Next-state decode and generation-tick qualification.
  always_comb begin
    nxt       = state;
    seed_last = (seed_cnt == SW'(SEED_CYC - 1));
    hit       = (div == rate_q);
    gen_inc   = gen_count + 1'b1;
    unique case (state)
      IDLE: begin
        if (seed_req)   nxt = SEED;
        else if (start) nxt = RUN;
      end
      SEED: begin
        if (seed_last)  nxt = PAUSE;
      end
      RUN: begin
        if (seed_req)   nxt = SEED;
        else if (stop)  nxt = PAUSE;
      end
      PAUSE: begin
        if (seed_req)   nxt = SEED;
        else if (start) nxt = RUN;
        else if (step)  nxt = STEP;
      end
      STEP: nxt = PAUSE;
      default: nxt = IDLE;
    endcase
    // A tick on the RUN exit cycle is dropped on purpose.
    tick = ((state == RUN) && (nxt == RUN) && hit) ||
           (nxt == STEP);
  end

  // State register, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      div       <= '0;
      rate_q    <= '0;
      seed_cnt  <= '0;
      gen_count <= '0;
      gen_wrap  <= 1'b0;
      lfsr_rst  <= 1'b1;
      grid_rst  <= 1'b1;
      lfsr_load <= 1'b0;
      grid_en   <= 1'b0;
      busy      <= 1'b0;
      state_o   <= 3'd0;
    end else begin
      state     <= nxt;
      state_o   <= nxt;
      busy      <= (nxt != IDLE);
      lfsr_rst  <= (nxt == IDLE);
      grid_rst  <= (nxt == IDLE);
      lfsr_load <= (nxt == SEED);
      grid_en   <= (nxt == SEED) || tick;
      gen_wrap  <= 1'b0;

      if ((nxt == SEED) && (state != SEED)) begin
        seed_cnt  <= '0;
        gen_count <= '0;
      end else begin
        if (state == SEED)
          seed_cnt <= seed_cnt + 1'b1;
        if (tick) begin
          gen_count <= gen_inc;
          gen_wrap  <= (gen_inc == '0);
        end
      end

      if ((nxt == RUN) && (state != RUN)) begin
        div    <= '0;
        rate_q <= rate;
      end else if (state == RUN) begin
        div <= hit ? '0 : div + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_life_sequencer.sv
// Randomized bench for life_sequencer.
// Compares every cycle with a behavioural model.
module tb_life_sequencer;

  localparam int CW = 8;
  localparam int GW = 4;
  localparam int SC = 64;

  logic          clk = 1'b0;
  logic          reset, start, stop, step, seed_req;
  logic [CW-1:0] rate;
  logic          lfsr_rst, lfsr_load, grid_rst, grid_en;
  logic [GW-1:0] gen_count;
  logic          gen_wrap, busy;
  logic [2:0]    state_o;

  int vectors = 0;
  int errors  = 0;

  int m_mode = 0;
  int m_gens = 0;
  int m_wrap = 0;
  int m_pulse = 0;
  int m_rq = 0;
  int m_t = 0;
  int m_seed = 0;

  always #5 clk = ~clk;

  life_sequencer #(
    .CNT_W(CW), .GEN_W(GW), .SEED_CYC(SC)
  ) dut (
    .clk(clk), .reset(reset), .start(start),
    .stop(stop), .step(step), .seed_req(seed_req),
    .rate(rate), .lfsr_rst(lfsr_rst),
    .lfsr_load(lfsr_load), .grid_rst(grid_rst),
    .grid_en(grid_en), .gen_count(gen_count),
    .gen_wrap(gen_wrap), .busy(busy),
    .state_o(state_o)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  task bump;
    m_gens  = (m_gens + 1) % (1 << GW);
    m_wrap  = (m_gens == 0);
    m_pulse = 1;
  endtask

  task go_seed;
    m_mode = 1;
    m_seed = 1;
    m_gens = 0;
  endtask

  task go_run(input int rt);
    m_mode = 2;
    m_rq   = rt;
    m_t    = 0;
  endtask

  task model(input logic r, st, sp, sx, sd,
             input int rt);
    m_wrap  = 0;
    m_pulse = 0;
    if (r) begin
      m_mode = 0;
      m_gens = 0;
      m_rq   = 0;
    end else begin
      case (m_mode)
        0: if (sd) go_seed();
           else if (st) go_run(rt);
        1: if (m_seed == SC) m_mode = 3;
           else m_seed++;
        2: if (sd) go_seed();
           else if (sp) m_mode = 3;
           else begin
             m_t++;
             if (m_t % (m_rq + 1) == 0) bump();
           end
        3: if (sd) go_seed();
           else if (st) go_run(rt);
           else if (sx) begin
             m_mode = 4;
             bump();
           end
        default: m_mode = 3;
      endcase
    end
  endtask

  task cycle(input logic r, st, sp, sx, sd,
             input logic [CW-1:0] rt);
    logic [8:0] exp_c;
    logic       ge;
    reset    = r;
    start    = st;
    stop     = sp;
    step     = sx;
    seed_req = sd;
    rate     = rt;
    @(posedge clk);
    model(r, st, sp, sx, sd, int'(rt));
    #1;
    ge = (m_mode == 1) || (m_mode == 4) || (m_pulse != 0);
    exp_c = {3'(m_mode), m_mode != 0, m_mode == 0,
             m_mode == 0, m_mode == 1, ge, m_wrap != 0};
    check("ctrl",
          {23'd0, state_o, busy, lfsr_rst, grid_rst,
           lfsr_load, grid_en, gen_wrap},
          {23'd0, exp_c});
    check("gen", {28'd0, gen_count}, m_gens);
  endtask

  task idle(input int n, input logic [CW-1:0] rt);
    for (int i = 0; i < n; i++)
      cycle(0, 0, 0, 0, 0, rt);
  endtask

  initial begin
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 1, 1, 1, 1, 5);
    cycle(0, 0, 1, 1, 0, 0);
    // reseed, inputs ignored during SEED
    cycle(0, 0, 0, 0, 1, 0);
    for (int i = 0; i < SC + 4; i++)
      cycle(0, i[0], i[1], i[2], i[3], 0);
    // run at rate 3, rate changes mid-run
    cycle(0, 1, 0, 0, 0, 3);
    for (int i = 0; i < 14; i++)
      cycle(0, 0, 0, 1, 0, CW'($urandom_range(0, 9)));
    cycle(0, 1, 1, 0, 0, 0);
    // rate 0: stop lands on a divider hit
    cycle(0, 1, 0, 0, 0, 0);
    idle(3, 0);
    cycle(0, 0, 1, 0, 0, 0);
    // step held
    for (int i = 0; i < 6; i++)
      cycle(0, 0, 0, 1, 0, 0);
    cycle(0, 0, 1, 0, 0, 0);
    // wrap at rate 0
    cycle(0, 1, 1, 0, 0, 0);
    idle(20, 0);
    cycle(0, 0, 1, 0, 0, 0);
    // reset mid-SEED
    cycle(0, 0, 0, 0, 1, 0);
    idle(20, 0);
    cycle(1, 0, 0, 0, 0, 0);
    idle(3, 0);
    // random traffic
    for (int i = 0; i < 3000; i++)
      cycle($urandom_range(0, 199) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 7) == 0,
            $urandom_range(0, 2) == 0,
            $urandom_range(0, 59) == 0,
            CW'($urandom_range(0, 5)));
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, errors);
    $finish;
  end

endmodule

// File: doc/life_sequencer.md
LIFE_SEQUENCER -- requirements
Module: life_sequencer

Interface
REQ-001 Parameter CNT_W, default 24, width of the generation-rate divider.
REQ-002 Parameter GEN_W, default 16, width of the generation counter.
REQ-003 Parameter SEED_CYC, default 64, number of cycles the LFSR seed is shifted into the grid.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  level; request free-running generation stepping.
REQ-007 stop  input  1  level; request pause of free-running stepping.
REQ-008 step  input  1  level; request one generation while paused.
REQ-009 seed_req  input  1  level; request reseed of grid from LFSR.
REQ-010 rate  input  CNT_W  cycles between generations in RUN is rate+1.
REQ-011 lfsr_rst  output  1  holds LFSR in its reset seed.
REQ-012 lfsr_load  output  1  routes LFSR output into grid shift input.
REQ-013 grid_rst  output  1  clears the grid.
REQ-014 grid_en  output  1  advances grid one cycle (shift in SEED, generation otherwise).
REQ-015 gen_count  output  GEN_W  generations computed since last seed.
REQ-016 gen_wrap  output  1  one-cycle pulse when gen_count wraps to 0.
REQ-017 busy  output  1  high in every state except IDLE.
REQ-018 state_o  output  3  encoded state: IDLE=0, SEED=1, RUN=2, PAUSE=3, STEP=4.

Function
REQ-019 FSM states IDLE, SEED, RUN, PAUSE, STEP; all outputs registered or decoded from registered state only (no input-to-output combinational path).
REQ-020 IDLE: lfsr_rst=1, grid_rst=1, lfsr_load=0, grid_en=0; seed_req -> SEED, else start -> RUN, else stay.
REQ-021 SEED: lfsr_rst=0, grid_rst=0, lfsr_load=1, grid_en=1 for exactly SEED_CYC consecutive cycles, then -> PAUSE; all inputs ignored while in SEED.
REQ-022 gen_count cleared to 0 on the cycle SEED is entered; gen_wrap not asserted by this clear.
REQ-023 RUN: lfsr_load=0, grid_rst=0, lfsr_rst=0; divider counts 0..rate_q; when divider==rate_q, grid_en=1 for one cycle, gen_count+1, divider -> 0.
REQ-024 rate latched into rate_q on every entry to RUN; changes to rate while in RUN have no effect; rate=0 gives grid_en every cycle.
REQ-025 Divider cleared to 0 on every RUN entry; first grid_en pulse occurs rate_q+1 cycles after entry.
REQ-026 RUN exit: seed_req -> SEED, else stop -> PAUSE; on the exit cycle grid_en=0 and gen_count unchanged even if divider==rate_q.
REQ-027 PAUSE: grid_en=0, lfsr_rst=0, grid_rst=0; priority seed_req > start (-> RUN) > step (-> STEP).
REQ-028 STEP: exactly one cycle, grid_en=1, gen_count+1, unconditionally -> PAUSE; step held high yields one generation per two cycles.
REQ-029 gen_count wraps from 2^GEN_W-1 to 0; gen_wrap=1 in the same cycle gen_count shows 0 after increment.
REQ-030 stop and step in IDLE, step in RUN, and stop in PAUSE are ignored.
REQ-031 Simultaneous start and stop in RUN: stop wins (-> PAUSE); in PAUSE: start wins (-> RUN).

Reset
REQ-032 reset sampled high at a rising edge forces next state IDLE, gen_count=0, divider=0, seed counter=0, rate_q=0, gen_wrap=0, from any state including mid-SEED.
REQ-033 Outputs during/after reset: lfsr_rst=1, grid_rst=1, lfsr_load=0, grid_en=0, busy=0, state_o=0.

Verification
REQ-034 Reset then seed_req one cycle -> lfsr_load=1 and grid_en=1 for exactly 64 cycles, then state_o=3, gen_count=0.
REQ-035 From PAUSE, rate=3, start -> grid_en pulses on cycles 4, 8, 12 after entry; gen_count=3 after 12 cycles; changing rate mid-RUN has no effect.
REQ-036 From RUN with rate=0, assert stop on a cycle divider==rate_q -> no grid_en that cycle, state_o=3, gen_count unchanged.
REQ-037 PAUSE with step held 6 cycles -> exactly 3 grid_en pulses, gen_count+3, state alternates 4/3.
REQ-038 GEN_W=4, rate=0, run 16 generations -> gen_count wraps 15->0 with single gen_wrap pulse; reset asserted mid-SEED -> IDLE next edge with all reset values of REQ-033.
